// File: rtl/sqrt16_if.sv
// Operand/result bundle for the sqrt16 root extractor.
// The master drives din/iv; the slave returns dout/ov.
interface sqrt16_if;
  logic [31:0] din;
  logic        iv;
  logic [15:0] dout;
  logic        ov;

  modport master (output din, output iv, input dout, input ov);
  modport slave  (input din, input iv, output dout, output ov);
endinterface

// File: rtl/sqrt16.sv
// Unsigned floor(sqrt) of a 32-bit radicand, restoring digit-by-digit.
// Produces one root bit per clock, 16 clocks from accept to ov.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not busy; accepts an iv strobe and latches din
// RUN   | busy; one root bit per clock, iv ignored, last step raises ov
module sqrt16 (
  input  logic      clk,
  input  logic      rst_n,
  sqrt16_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] op_q,    op_d;
  logic [17:0] rem_q,   rem_d;
  logic [15:0] root_q,  root_d;
  logic [15:0] dout_q,  dout_d;
  logic        ov_q,    ov_d;

  logic [17:0] rem_sh;
  logic [17:0] trial;
  logic        fits;
  logic [15:0] root_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
    end
  end

  // A set bit in rem_q[17:16] means the shifted remainder already exceeds
  // any 18-bit trial value, so the subtraction is taken regardless.
  always_comb begin
    rem_sh    = {rem_q[15:0], op_q[31:30]};
    trial     = {root_q, 2'b01};
    fits      = (rem_q[17:16] != 2'b00) || (rem_sh >= trial);
    root_step = {root_q[14:0], fits};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    dout_d  = dout_q;
    ov_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.iv) begin
          op_d    = bus.din;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = 4'd15;
          state_d = RUN;
        end
      end
      RUN: begin
        op_d   = {op_q[29:0], 2'b00};
        rem_d  = fits ? (rem_sh - trial) : rem_sh;
        root_d = root_step;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          dout_d  = root_step;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.ov   = ov_q;

endmodule

// File: tb/tb_sqrt16.sv
// Directed and swept checks of sqrt16 against a floor-sqrt reference.
module tb_sqrt16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  sqrt16_if bus ();

  sqrt16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drives a one-cycle iv; returns at the negedge just after the accept edge.
  task automatic send(input logic [31:0] v);
    @(negedge clk);
    bus.din = v;
    bus.iv  = 1'b1;
    @(negedge clk);
    bus.iv  = 1'b0;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (bus.ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_one(input string tag, input logic [31:0] v, input logic [15:0] exp);
    int lat;
    send(v);
    wait_ov(lat);
    chk({tag, "_lat"}, lat, 16);
    chk(tag, {16'd0, bus.dout}, {16'd0, exp});
    @(negedge clk);
    chk({tag, "_ov1"}, {31'd0, bus.ov}, 0);
  endtask

  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint r;
    longint x;
    x = longint'(v);
    r = longint'($floor($sqrt(real'(x))));
    while ((r + 1) * (r + 1) <= x) r++;
    while (r * r > x) r--;
    return r[15:0];
  endfunction

  initial begin
    int          lat;
    int          pulses;
    int          bad;
    logic [31:0] v;
    logic [15:0] prev;
    logic [15:0] exp;

    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    bus.iv  = 1'b0;
    bus.din = '0;

    repeat (3) @(negedge clk);
    chk("rst_dout", {16'd0, bus.dout}, 0);
    chk("rst_ov", {31'd0, bus.ov}, 0);
    rst_n = 1'b1;

    do_one("d140", 32'd140, 16'd11);
    do_one("d144", 32'd144, 16'd12);
    do_one("d36864", 32'd36864, 16'd192);
    do_one("d65025", 32'd65025, 16'd255);
    do_one("d4294836225", 32'd4294836225, 16'd65535);
    do_one("d148", 32'd148, 16'd12);
    do_one("d0", 32'd0, 16'd0);
    do_one("dmax", 32'hFFFF_FFFF, 16'd65535);
    do_one("d3", 32'd3, 16'd1);
    do_one("dFFFE0001", 32'hFFFE_0001, 16'd65535);
    do_one("dFFFE0000", 32'hFFFE_0000, 16'd65534);

    // iv while busy must be dropped
    send(32'd65025);
    repeat (4) @(negedge clk);
    bus.din = 32'd9;
    bus.iv  = 1'b1;
    @(negedge clk);
    bus.iv  = 1'b0;
    wait_ov(lat);
    chk("busy_lat", lat, 11);
    chk("busy_val", {16'd0, bus.dout}, 255);
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.ov === 1'b1) pulses++;
    end
    chk("busy_extra_ov", pulses, 0);
    chk("busy_hold", {16'd0, bus.dout}, 255);

    // back-to-back: second accept on the ov edge's following edge
    send(32'd144);
    wait_ov(lat);
    chk("b2b_lat1", lat, 16);
    chk("b2b_val1", {16'd0, bus.dout}, 12);
    bus.din = 32'd36864;
    bus.iv  = 1'b1;
    @(negedge clk);
    bus.iv  = 1'b0;
    chk("b2b_ov1", {31'd0, bus.ov}, 0);
    wait_ov(lat);
    chk("b2b_lat2", lat, 16);
    chk("b2b_val2", {16'd0, bus.dout}, 192);

    // async reset mid-run
    send(32'hFFFF_FFFF);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dout", {16'd0, bus.dout}, 0);
    chk("arst_ov", {31'd0, bus.ov}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.ov === 1'b1) pulses++;
    end
    chk("arst_no_ov", pulses, 0);
    do_one("arst_next", 32'd144, 16'd12);

    // swept operands: one ov each, dout held until the ov edge
    prev = 16'd12;
    for (int k = 0; k < 2000; k++) begin
      case (k % 4)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 65535);
        2:       begin v = $urandom_range(0, 65535); v = v * v; end
        default: begin v = $urandom_range(1, 65535); v = v * v - 1; end
      endcase
      exp = ref_sqrt(v);
      send(v);
      pulses = 0;
      bad    = 0;
      for (int c = 1; c <= 18; c++) begin
        @(negedge clk);
        if (bus.ov === 1'b1) begin
          pulses++;
          if (c != 16) bad++;
        end
        if (c < 16 && bus.dout !== prev) bad++;
        if (c >= 16 && bus.dout !== exp) bad++;
      end
      chk("sweep_ovcnt", pulses, 1);
      chk("sweep_timing", bad, 0);
      chk("sweep_val", {16'd0, bus.dout}, {16'd0, exp});
      prev = exp;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
